// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) request scheduler.
`default_nettype none

package hamming_pkg;

  localparam int CW_W = 7;
  localparam int DW_W = 4;

  // Codeword bit positions: parity at powers of two, data elsewhere
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/hamming_codec.sv
// Combinational Hamming(7,4) encoder / single-error-correcting decoder.
`default_nettype none

module hamming_codec
  import hamming_pkg::*;
(
  input  logic            mode,
  input  logic [CW_W-1:0] word,
  output logic [CW_W-1:0] result,
  output logic            err
);

  logic [DW_W-1:0] d;
  logic [2:0]      syn;
  logic [CW_W-1:0] fixed;

  always_comb begin
    result = '0;
    err    = 1'b0;
    d      = '0;
    syn    = '0;
    fixed  = word;
    if (!mode) begin
      d = word[DW_W-1:0];
      result[P1_POS] = d[0] ^ d[1] ^ d[3];
      result[P2_POS] = d[0] ^ d[2] ^ d[3];
      result[D0_POS] = d[0];
      result[P4_POS] = d[1] ^ d[2] ^ d[3];
      result[D1_POS] = d[1];
      result[D2_POS] = d[2];
      result[D3_POS] = d[3];
    end else begin
      syn[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
      syn[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
      syn[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
      // Syndrome value is the 1-based position of the faulty bit
      if (syn != 3'd0) begin
        fixed[syn - 3'd1] = ~word[syn - 3'd1];
        err = 1'b1;
      end
      result = {3'b000, fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_scheduler.sv
// Round-robin scheduler sharing one Hamming codec between request channels.
// Optional corrected-error counter enabled by HAMMING_SCHED_STATS_EN.
`default_nettype none

module hamming_scheduler
  import hamming_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_valid,
  output logic [NUM_CH-1:0]      req_ready,
  input  logic [NUM_CH-1:0]      req_mode,
  input  logic [CW_W*NUM_CH-1:0] req_word,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [CW_W-1:0]        rsp_data,
  output logic                   rsp_err,
  output logic [CNT_W-1:0]       corr_count
);

  sched_state_t state, state_nx;

  logic              ptr;
  logic              gnt_id;
  logic [NUM_CH-1:0] gnt_oh;
  logic              accept;

  logic              op_mode;
  logic [CW_W-1:0]   op_word;
  logic              op_id;

  logic [CW_W-1:0]   codec_result;
  logic              codec_err;

  always_comb begin
    gnt_id = 1'b0;
    gnt_oh = '0;
    if (req_valid[0] && req_valid[1]) gnt_id = ptr;
    else                              gnt_id = req_valid[1];
    if (|req_valid) gnt_oh[gnt_id] = 1'b1;
  end

  assign req_ready = (state == S_IDLE && !rst) ? gnt_oh : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      op_mode  <= 1'b0;
      op_word  <= '0;
      op_id    <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_mode <= req_mode[gnt_id];
        op_word <= req_word[int'(gnt_id)*CW_W +: CW_W];
        op_id   <= gnt_id;
        // Next contention goes to whichever channel was just passed over
        ptr     <= ~gnt_id;
      end
      if (state == S_EXEC) begin
        rsp_data <= codec_result;
        rsp_err  <= codec_err;
        rsp_id   <= op_id;
      end
    end
  end

  hamming_codec u_codec (
    .mode   (op_mode),
    .word   (op_word),
    .result (codec_result),
    .err    (codec_err)
  );

`ifdef HAMMING_SCHED_STATS_EN
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (rsp_valid && rsp_ready && rsp_err && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign corr_count = count;
`else
  assign corr_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/hamming_scheduler.md
HAMMING_SCHEDULER -- requirements
Module: hamming_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal values 2 only in this release).
REQ-002 SHALL have parameter CNT_W, default 8, width of the corrected-error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_CH, per-channel request valid.
REQ-006 SHALL have port req_ready, output, NUM_CH, per-channel accept (one-hot or zero).
REQ-007 SHALL have port req_mode, input, NUM_CH, per-channel operation: 0 encode, 1 decode.
REQ-008 SHALL have port req_word, input, 7*NUM_CH, per-channel operand; encode uses bits [3:0], decode uses [6:0].
REQ-009 SHALL have port rsp_valid, input/output: output, 1, result valid.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_id, output, 1, channel index of the result.
REQ-012 SHALL have port rsp_data, output, 7, codeword (encode) or {3'b0, data} (decode).
REQ-013 SHALL have port rsp_err, output, 1, decode found and corrected a single-bit error.
REQ-014 SHALL have port corr_count, output, CNT_W, corrected-error count (see Configuration).

Function
REQ-015 SHALL use codeword layout code[0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3; p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
REQ-016 SHALL decode via syndrome s={s4,s2,s1}; s!=0 flips code bit s-1, sets rsp_err=1; s=0 sets rsp_err=0; encode always rsp_err=0.
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; EXEC lasts exactly one cycle; RESP holds until rsp_valid && rsp_ready.
REQ-018 SHALL assert req_ready[k] only in IDLE, only for the granted channel, combinationally from req_valid; handshake = req_valid[k] && req_ready[k] latches mode, word, id and moves to EXEC.
REQ-019 SHALL arbitrate round-robin: when both valid, grant the channel not granted last; single valid channel granted immediately; pointer favours ch0 after reset.
REQ-020 SHALL register codec result at end of EXEC; rsp_valid rises the cycle after EXEC (accept at cycle N -> rsp_valid at N+2).
REQ-021 SHALL hold rsp_id/rsp_data/rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL, on rsp handshake, return to IDLE next cycle; a new accept earliest one cycle after the response handshake (no overlap).
REQ-023 SHALL keep rsp_data/rsp_err/rsp_id at their last value when rsp_valid=0 (don't-care for checking).

Reset
REQ-024 SHALL on rst: state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, RR pointer to ch0, corr_count=0.
REQ-025 SHALL on rst asserted mid-EXEC or mid-RESP discard the in-flight operation with no response and no count update.
REQ-026 SHALL drive req_ready=0 during any cycle rst=1.

Configuration
REQ-027 SHALL, with HAMMING_SCHED_STATS_EN defined, increment corr_count by 1 on each response handshake with rsp_err=1, saturating at all-ones.
REQ-028 SHALL, without HAMMING_SCHED_STATS_EN, tie corr_count to 0 and contain no counter flops.

Structure
REQ-029 SHALL place FSM state enum, codeword bit-position constants and CW_W=7 / DW_W=4 in package hamming_pkg.
REQ-030 SHALL instantiate one combinational sub-module hamming_codec (mode, word in; result, err out), shared by all channels.

Verification
REQ-031 SHALL check encode: ch0 mode=0 word=4'hB -> rsp_data=7'h55, rsp_err=0, rsp_id=0, rsp_valid two cycles after accept.
REQ-032 SHALL check clean decode: ch1 mode=1 word=7'h55 -> rsp_data=7'h0B, rsp_err=0, rsp_id=1.
REQ-033 SHALL check corrected decode: word=7'h51 (d0 flipped) -> rsp_data=7'h0B, rsp_err=1, corr_count 0->1 when STATS_EN.
REQ-034 SHALL check arbitration: both channels valid continuously -> grants alternate ch0, ch1, ch0, ch1.
REQ-035 SHALL check backpressure: rsp_ready=0 for 5 cycles -> rsp outputs stable, req_ready=0 for both channels throughout.
REQ-036 SHALL check reset mid-RESP: rst one cycle while rsp_valid=1 -> rsp_valid=0 next cycle, corr_count=0, ch0 granted first afterwards.
